fp_posit_norm: RTL and testbench
================================

Name: fp_posit_norm

Overview:
Output stage directly downstream of fp_posit_acc. It takes the accumulator's sign, exponent and 32-bit unsigned fixed-point magnitude, and normalizes the result into an IEEE-754 binary16 word. Normalization uses leading-one detection, alignment shift and round-to-nearest-even. The block is a 3-stage pipeline with a valid strobe and no backpressure, so it accepts one result per cycle.

Parameters:
ACC_W, 32, width of the fixed-point magnitude input
EXP_W, 5, width of the accumulator exponent input and of the binary16 exponent field
FRAC_POS, 10, binary-point position in fixed_point_in (bits below FRAC_POS are fraction)
BIAS, 15, exponent bias shared by exp_in and the binary16 output

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  sign_in/exp_in/fixed_point_in valid this cycle
sign_in  input  1  sign of the accumulated value (1 = negative)
exp_in  input  EXP_W  biased exponent from the accumulator (its exp_out)
fixed_point_in  input  ACC_W  unsigned magnitude from the accumulator (its fixed_point_out)
out_valid  output  1  fp_out/ovf/unf valid this cycle
fp_out  output  16  binary16 result {sign, exp[4:0], man[9:0]}
ovf  output  1  result overflowed to infinity
unf  output  1  nonzero result flushed to zero

Behaviour:
- Input value definition: (-1)^sign_in × fixed_point_in × 2^(exp_in − BIAS − FRAC_POS).
- Reset:
  - While rst is high: out_valid=0, fp_out=16'h0000, ovf=0, unf=0.
  - All pipeline valid bits clear immediately (asynchronous).
  - Anything in flight is discarded and never emerges.
- Latency:
  - A sample accepted with in_valid=1 at edge N appears with out_valid=1 after edge N+3.
  - Throughput is 1 per cycle. Samples stay in order.
  - When out_valid=0, fp_out/ovf/unf hold their last values.
- Stage 1 (register and detect):
  - Register the inputs.
  - Compute p = index of the most significant 1 in fixed_point_in (0..ACC_W−1).
  - Compute zero flag z = (fixed_point_in == 0).
- Stage 2 (align and exponent):
  - Compute e = exp_in + p − FRAC_POS as a signed value of at least EXP_W+3 bits.
  - Mantissa and rounding bits:
    - If p ≥ 10: man = bits [p−1:p−10], guard = bit p−11, sticky = OR of bits below p−11 (0 when they do not exist).
    - If p < 10: left-shift so that man holds the bits below p; guard=0, sticky=0.
- Stage 3 (round and pack):
  - Round to nearest, ties to even: round up when guard & (sticky | man[0]).
  - If the round-up carries out of man: man=0, e=e+1.
  - Result selection, in priority order:
    - z=1: fp_out=16'h0000, ovf=0, unf=0. The sign is dropped, so the output is always +0.
    - e ≤ 0 (pre-round value): fp_out={sign,15'h0}, unf=1. No subnormals are produced.
    - Final e ≥ 31: fp_out={sign,5'h1F,10'h0}, ovf=1.
    - Otherwise: fp_out={sign, e[4:0], man}.
- ovf and unf are never both 1.
- No NaN is ever produced.

Test Plan:
1. in_valid=1, sign=0, exp_in=15, fixed_point_in=0x400 -> out_valid exactly 3 cycles later, fp_out=0x3C00, ovf=unf=0.
2. sign=1, exp_in=15, fixed_point_in=0x600 -> 0xBE00.
3. Rounding, exp_in=15 for all three inputs:
   - 0x1001 -> 0x4400 (round down)
   - 0x1002 -> 0x4400 (tie, even)
   - 0x1006 -> 0x4402 (tie, round up)
4. Mantissa carry: exp_in=15, fixed_point_in=0xFFF -> 0x4400. Also exp_in=20, fixed_point_in=0xFFFF_FFFF -> 0x7C00 with ovf=1 (e=41, overflow).
5. Boundaries:
   - exp_in=31, fixed_point_in=0x8000_0000 -> 0x7C00, ovf=1.
   - exp_in=0, sign=1, fixed_point_in=1 -> 0x8000, unf=1.
   - fixed_point_in=0, sign=1 -> 0x0000, flags 0.
6. Streaming and reset:
   - Drive vectors 1, 2 and 3a on three consecutive cycles -> out_valid high for three consecutive cycles with 0x3C00, 0xBE00, 0x4400 in order.
   - Assert rst asynchronously mid-stream -> out_valid drops immediately without waiting for a clock edge, and no stale result appears after rst is released.

Source files
------------

// File: rtl/fp_posit_norm.sv
// rtl/fp_posit_norm.sv - normalizes accumulator fixed-point output to binary16
// Ports: clk/rst (async active-high); in_valid, sign_in, exp_in, fixed_point_in
// from the accumulator; out_valid, fp_out {sign, exp, man}, ovf (to infinity),
// unf (nonzero flushed to zero). Four register levels, one result per cycle.
module fp_posit_norm #(
  parameter int ACC_W    = 32,
  parameter int EXP_W    = 5,
  parameter int FRAC_POS = 10,
  parameter int BIAS     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [ACC_W-1:0] fixed_point_in,
  output logic             out_valid,
  output logic [15:0]      fp_out,
  output logic             ovf,
  output logic             unf
);

  localparam int MAN_W = 10;
  localparam int P_W   = $clog2(ACC_W);
  localparam int E_W   = EXP_W + 3;
  // First exponent code that no longer fits a finite binary16 value.
  localparam logic signed [E_W-1:0] E_OVF  = E_W'(2 * BIAS + 1);
  localparam logic signed [E_W-1:0] E_FRAC = E_W'(FRAC_POS);

  // Stage 1: registered inputs plus leading-one position and zero flag.
  logic             v1_d, v1_q, sign1_d, sign1_q, z1_d, z1_q;
  logic [EXP_W-1:0] exp1_d, exp1_q;
  logic [ACC_W-1:0] fx1_d, fx1_q;
  logic [P_W-1:0]   p1_d, p1_q;

  // Stage 2: unbiased-to-output exponent and aligned mantissa with round bits.
  logic                  v2_d, v2_q, sign2_d, sign2_q, z2_d, z2_q;
  logic signed [E_W-1:0] e2_d, e2_q;
  logic [MAN_W-1:0]      man2_d, man2_q;
  logic                  g2_d, g2_q, s2_d, s2_q;

  // Stage 3: rounded mantissa and exponent; tiny3 remembers the pre-round e <= 0.
  logic                  v3_d, v3_q, sign3_d, sign3_q, z3_d, z3_q, tiny3_d, tiny3_q;
  logic signed [E_W-1:0] e3_d, e3_q;
  logic [MAN_W-1:0]      man3_d, man3_q;

  // Output stage: holds its value whenever no result is retiring.
  logic        out_valid_d, out_valid_q, ovf_d, ovf_q, unf_d, unf_q;
  logic [15:0] fp_out_d, fp_out_q;

  logic [P_W:0]     lsh;
  logic [ACC_W-1:0] aligned;
  logic             rnd_up;
  logic [MAN_W:0]   man_sum;

  always_comb begin
    v1_d    = in_valid;
    sign1_d = sign_in;
    exp1_d  = exp_in;
    fx1_d   = fixed_point_in;
    z1_d    = (fixed_point_in == '0);
    p1_d    = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (fixed_point_in[i]) p1_d = P_W'(i);
    end
  end

  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    z2_d    = z1_q;
    e2_d    = E_W'(exp1_q) + E_W'(p1_q) - E_FRAC;
    // Shifting by ACC_W-p pushes the implicit leading one out of the word, so
    // the top bits are exactly the fraction, then guard, then sticky bits.
    // For p < MAN_W the zeros shifted in give guard = sticky = 0.
    lsh     = (P_W+1)'(ACC_W) - {1'b0, p1_q};
    aligned = fx1_q << lsh;
    man2_d  = aligned[ACC_W-1 -: MAN_W];
    g2_d    = aligned[ACC_W-1-MAN_W];
    s2_d    = |aligned[ACC_W-2-MAN_W:0];
  end

  always_comb begin
    v3_d    = v2_q;
    sign3_d = sign2_q;
    z3_d    = z2_q;
    tiny3_d = (e2_q <= 0);
    rnd_up  = g2_q & (s2_q | man2_q[0]);
    man_sum = {1'b0, man2_q} + (MAN_W+1)'(rnd_up);
    // A carry out means the significand rolled over to 2.0: man is already zero.
    man3_d  = man_sum[MAN_W-1:0];
    e3_d    = e2_q + E_W'(man_sum[MAN_W]);
  end

  always_comb begin
    out_valid_d = v3_q;
    fp_out_d    = fp_out_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (v3_q) begin
      if (z3_q) begin
        fp_out_d = 16'h0000;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
      end else if (tiny3_q) begin
        fp_out_d = {sign3_q, 15'h0000};
        ovf_d    = 1'b0;
        unf_d    = 1'b1;
      end else if (e3_q >= E_OVF) begin
        fp_out_d = {sign3_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        ovf_d    = 1'b1;
        unf_d    = 1'b0;
      end else begin
        fp_out_d = {sign3_q, e3_q[EXP_W-1:0], man3_q};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; sign1_q <= 1'b0; z1_q <= 1'b0;
      exp1_q <= '0; fx1_q <= '0; p1_q <= '0;
      v2_q <= 1'b0; sign2_q <= 1'b0; z2_q <= 1'b0;
      e2_q <= '0; man2_q <= '0; g2_q <= 1'b0; s2_q <= 1'b0;
      v3_q <= 1'b0; sign3_q <= 1'b0; z3_q <= 1'b0; tiny3_q <= 1'b0;
      e3_q <= '0; man3_q <= '0;
      out_valid_q <= 1'b0; fp_out_q <= 16'h0000; ovf_q <= 1'b0; unf_q <= 1'b0;
    end else begin
      v1_q <= v1_d; sign1_q <= sign1_d; z1_q <= z1_d;
      exp1_q <= exp1_d; fx1_q <= fx1_d; p1_q <= p1_d;
      v2_q <= v2_d; sign2_q <= sign2_d; z2_q <= z2_d;
      e2_q <= e2_d; man2_q <= man2_d; g2_q <= g2_d; s2_q <= s2_d;
      v3_q <= v3_d; sign3_q <= sign3_d; z3_q <= z3_d; tiny3_q <= tiny3_d;
      e3_q <= e3_d; man3_q <= man3_d;
      out_valid_q <= out_valid_d; fp_out_q <= fp_out_d; ovf_q <= ovf_d; unf_q <= unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign fp_out    = fp_out_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_fp_posit_norm.sv
// tb/tb_fp_posit_norm.sv - self-checking bench for fp_posit_norm
module tb_fp_posit_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = '0;
  logic [31:0] fixed_point_in = '0;
  logic        out_valid;
  logic [15:0] fp_out;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [15:0] fp;
    bit          ovf;
    bit          unf;
  } exp_t;

  typedef struct {
    bit          s;
    int          e;
    logic [31:0] fx;
    logic [15:0] fp;
    bit          ovf;
    bit          unf;
  } vec_t;

  fp_posit_norm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sign_in(sign_in),
    .exp_in(exp_in), .fixed_point_in(fixed_point_in),
    .out_valid(out_valid), .fp_out(fp_out), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit v, input bit s, input int e, input logic [31:0] fx);
    in_valid       = v;
    sign_in        = s;
    exp_in         = 5'(e);
    fixed_point_in = fx;
  endtask

  // Value = fx * 2^(e_in - 25); rounded with integer quotient/remainder.
  function automatic void ref_model(input bit s, input int e_in, input longint fx,
                                    output logic [15:0] fp, output bit o, output bit u);
    int     p, e, ef, sh;
    longint q, rem, half;
    fp = 16'h0000; o = 0; u = 0;
    if (fx == 0) return;
    p = $clog2(fx + 1) - 1;
    e = e_in + p - 10;
    if (p >= 10) begin
      sh  = p - 10;
      q   = fx >> sh;
      rem = fx - (q << sh);
      if (sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
      end
    end else begin
      q = fx << (10 - p);
    end
    ef = e;
    if (q == 2048) begin q = 1024; ef = e + 1; end
    if (e <= 0) begin
      fp = {s, 15'h0}; u = 1;
    end else if (ef >= 31) begin
      fp = {s, 5'h1F, 10'h0}; o = 1;
    end else begin
      fp = {s, 5'(ef), 10'(q - 1024)};
    end
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (fp_out !== 16'h0000) begin failures++; $display("FAIL reset_fp got=%h want=0000", fp_out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    checks++; if (unf !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b want=0", unf); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    vec_t vt[14];
    logic [15:0] held;
    vt[0]  = '{0, 15, 32'h400,       16'h3C00, 0, 0};
    vt[1]  = '{1, 15, 32'h600,       16'hBE00, 0, 0};
    vt[2]  = '{0, 15, 32'h1001,      16'h4400, 0, 0};
    vt[3]  = '{0, 15, 32'h1002,      16'h4400, 0, 0};
    vt[4]  = '{0, 15, 32'h1006,      16'h4402, 0, 0};
    vt[5]  = '{0, 15, 32'hFFF,       16'h4400, 0, 0};
    vt[6]  = '{0, 20, 32'hFFFF_FFFF, 16'h7C00, 1, 0};
    vt[7]  = '{0, 31, 32'h8000_0000, 16'h7C00, 1, 0};
    vt[8]  = '{1, 0,  32'h1,         16'h8000, 0, 1};
    vt[9]  = '{1, 15, 32'h0,         16'h0000, 0, 0};
    vt[10] = '{1, 10, 32'h1,         16'h8000, 0, 1};
    vt[11] = '{0, 11, 32'h1,         16'h0400, 0, 0};
    vt[12] = '{0, 30, 32'h7FF,       16'h7BFF, 0, 0};
    vt[13] = '{0, 29, 32'hFFF,       16'h7C00, 1, 0};
    foreach (vt[i]) begin
      drive(1, vt[i].s, vt[i].e, vt[i].fx);
      tick();
      drive(0, 0, 0, 0);
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early got=%b want=0", i, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_valid got=%b want=1", i, out_valid); end
      checks++; if (fp_out !== vt[i].fp) begin failures++; $display("FAIL dir%0d_fp got=%h want=%h", i, fp_out, vt[i].fp); end
      checks++; if (ovf !== vt[i].ovf) begin failures++; $display("FAIL dir%0d_ovf got=%b want=%b", i, ovf, vt[i].ovf); end
      checks++; if (unf !== vt[i].unf) begin failures++; $display("FAIL dir%0d_unf got=%b want=%b", i, unf, vt[i].unf); end
      held = fp_out;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_drop got=%b want=0", i, out_valid); end
      checks++; if (fp_out !== vt[i].fp) begin failures++; $display("FAIL dir%0d_hold got=%h want=%h", i, fp_out, held); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want[3];
    want[0] = 16'h3C00; want[1] = 16'hBE00; want[2] = 16'h4400;
    drive(1, 0, 15, 32'h400);  tick();
    drive(1, 1, 15, 32'h600);  tick();
    drive(1, 0, 15, 32'h1001); tick();
    drive(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b%0d_valid got=%b want=1", k, out_valid); end
      checks++; if (fp_out !== want[k]) begin failures++; $display("FAIL b2b%0d_fp got=%h want=%h", k, fp_out, want[k]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        x;
    logic [15:0] fp;
    bit          o, u, v, s;
    int          e;
    logic [31:0] fx;
    for (int n = 0; n < 420; n++) begin
      v  = (n < 400) && ($urandom_range(0, 9) < 7);
      s  = 1'($urandom);
      e  = $urandom_range(0, 31);
      fx = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      drive(v, s, e, fx);
      tick();
      if (v) begin
        ref_model(s, e, longint'(fx), fp, o, u);
        x = '{cyc + 3, fp, o, u};
        q.push_back(x);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        x = q.pop_front();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=1", cyc, out_valid); end
        checks++; if (fp_out !== x.fp) begin failures++; $display("FAIL rnd_fp cyc=%0d got=%h want=%h", cyc, fp_out, x.fp); end
        checks++; if (ovf !== x.ovf || unf !== x.unf) begin
          failures++; $display("FAIL rnd_flags cyc=%0d got=%b%b want=%b%b", cyc, ovf, unf, x.ovf, x.unf);
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_idle cyc=%0d got=%b want=0", cyc, out_valid); end
      end
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 15, 32'h600 + 32'(k));
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_prevalid got=%b want=1", out_valid); end
    #3;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    checks++; if (fp_out !== 16'h0000) begin failures++; $display("FAIL mid_async_fp got=%h want=0000", fp_out); end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale%0d got=%b want=0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
